// File: rtl/td4_run_ctrl.sv
// Run/step/load controller for a TD4-style core: issues core clock-enables
// through a selectable prescaler, handles breakpoints, and streams program bytes.
module td4_run_ctrl #(
    parameter int SLOW_LOG2 = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       mode_load,
    input  logic       wr_strobe,
    input  logic [7:0] wr_data,
    input  logic       run,
    input  logic       step,
    input  logic [1:0] div_sel,
    input  logic       bp_en,
    input  logic [3:0] bp_addr,
    input  logic [3:0] pc,
    output logic       core_ce,
    output logic       prog_we,
    output logic [3:0] prog_addr,
    output logic [7:0] prog_wdata,
    output logic [2:0] state,
    output logic       halted,
    output logic       load_done
);

    localparam int PW = SLOW_LOG2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_STEP = 3'd3,
        S_HALT = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    addr_q, addr_d;
    logic [1:0]    div_q, div_d;
    logic          skip_q, skip_d;
    logic          from_halt_q, from_halt_d;
    logic          wr_s1_q, wr_s1_d, wr_s2_q, wr_s2_d;
    logic          st_s1_q, st_s1_d, st_s2_q, st_s2_d;
    logic          run_q, run_d;

    logic          wr_edge, st_edge, run_rise, div_chg, due, bp_hit;
    logic          core_ce_c, prog_we_c, load_done_c;

    function automatic logic [PW-1:0] term_of(input logic [1:0] sel);
        case (sel)
            2'd0:    term_of = '0;
            2'd1:    term_of = PW'(3);
            2'd2:    term_of = PW'(15);
            default: term_of = '1;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        addr_d      = addr_q;
        div_d       = div_q;
        skip_d      = skip_q;
        from_halt_d = from_halt_q;
        core_ce_c   = 1'b0;
        prog_we_c   = 1'b0;
        load_done_c = 1'b0;

        wr_edge  = wr_s1_q & ~wr_s2_q;
        st_edge  = st_s1_q & ~st_s2_q;
        run_rise = run & ~run_q;
        div_chg  = (div_sel != div_q);
        due      = !div_chg && (presc_q == term_of(div_sel));
        bp_hit   = bp_en && (pc == bp_addr) && !skip_q;

        // Edge trackers keep sampling while frozen so edges during ena=0 are dropped.
        wr_s1_d = wr_strobe;
        wr_s2_d = wr_s1_q;
        st_s1_d = step;
        st_s2_d = st_s1_q;
        run_d   = run;

        if (ena) begin
            div_d = div_sel;
            case (state_q)
                S_IDLE: begin
                    presc_d = '0;
                    if (mode_load) begin
                        state_d = S_LOAD;
                        addr_d  = 4'd0;
                    end else if (run) begin
                        state_d = S_RUN;
                    end else if (st_edge) begin
                        state_d     = S_STEP;
                        from_halt_d = 1'b0;
                    end
                end
                S_LOAD: begin
                    if (wr_edge) begin
                        prog_we_c = 1'b1;
                        addr_d    = addr_q + 4'd1;
                        if (addr_q == 4'd15) begin
                            load_done_c = 1'b1;
                            state_d     = S_IDLE;
                        end
                    end
                    if (!mode_load) state_d = S_IDLE;
                end
                S_RUN: begin
                    if (!run) begin
                        state_d = S_IDLE;
                        presc_d = '0;
                    end else if (div_chg) begin
                        presc_d = '0;
                    end else if (due) begin
                        presc_d = '0;
                        if (bp_hit) begin
                            state_d = S_HALT;
                        end else begin
                            core_ce_c = 1'b1;
                            skip_d    = 1'b0;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                S_STEP: begin
                    core_ce_c = 1'b1;
                    skip_d    = 1'b0;
                    presc_d   = '0;
                    state_d   = from_halt_q ? S_HALT : S_IDLE;
                end
                S_HALT: begin
                    // Re-arm skip so the PC parked on the breakpoint can execute once.
                    skip_d  = 1'b1;
                    presc_d = '0;
                    if (mode_load) begin
                        state_d = S_LOAD;
                        addr_d  = 4'd0;
                    end else if (st_edge) begin
                        state_d     = S_STEP;
                        from_halt_d = 1'b1;
                    end else if (run_rise) begin
                        state_d = S_RUN;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            addr_q      <= 4'd0;
            div_q       <= 2'd0;
            skip_q      <= 1'b0;
            from_halt_q <= 1'b0;
            wr_s1_q     <= 1'b0;
            wr_s2_q     <= 1'b0;
            st_s1_q     <= 1'b0;
            st_s2_q     <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            addr_q      <= addr_d;
            div_q       <= div_d;
            skip_q      <= skip_d;
            from_halt_q <= from_halt_d;
            wr_s1_q     <= wr_s1_d;
            wr_s2_q     <= wr_s2_d;
            st_s1_q     <= st_s1_d;
            st_s2_q     <= st_s2_d;
            run_q       <= run_d;
        end
    end

    assign core_ce    = core_ce_c;
    assign prog_we    = prog_we_c;
    assign prog_addr  = addr_q;
    assign prog_wdata = prog_we_c ? wr_data : 8'h00;
    assign load_done  = load_done_c;
    assign state      = state_q;
    assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_td4_run_ctrl.sv
// Directed bench for td4_run_ctrl: load, rate, breakpoint, resume, reset, freeze.
module tb_td4_run_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       mode_load;
    logic       wr_strobe;
    logic [7:0] wr_data;
    logic       run;
    logic       step;
    logic [1:0] div_sel;
    logic       bp_en;
    logic [3:0] bp_addr;
    logic [3:0] pc;
    logic       core_ce;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_wdata;
    logic [2:0] state;
    logic       halted;
    logic       load_done;

    int nvec = 0;
    int nmis = 0;

    td4_run_ctrl #(.SLOW_LOG2(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .mode_load  (mode_load),
        .wr_strobe  (wr_strobe),
        .wr_data    (wr_data),
        .run        (run),
        .step       (step),
        .div_sel    (div_sel),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc         (pc),
        .core_ce    (core_ce),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .state      (state),
        .halted     (halted),
        .load_done  (load_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr_pulse(input logic [7:0] d, input logic [3:0] exp_addr, input logic last);
        wr_data   = d;
        wr_strobe = 1'b1;
        tick();
        chk("load_we", prog_we, 8'd1);
        chk("load_addr", prog_addr, exp_addr);
        chk("load_data", prog_wdata, d);
        chk("load_done", load_done, last);
        chk("load_ce", core_ce, 8'd0);
        wr_strobe = 1'b0;
        if (last) mode_load = 1'b0;
        tick();
        chk("load_we_low", prog_we, 8'd0);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; mode_load = 1'b0; wr_strobe = 1'b0; wr_data = 8'h00;
        run = 1'b0; step = 1'b0; div_sel = 2'd0; bp_en = 1'b0; bp_addr = 4'd0; pc = 4'd0;
        tick();
        tick();
        chk("rst_state", state, 8'd0);
        chk("rst_ce", core_ce, 8'd0);
        chk("rst_we", prog_we, 8'd0);
        chk("rst_addr", prog_addr, 8'd0);
        chk("rst_halted", halted, 8'd0);
        rst_n = 1'b1;
        tick();

        // Full 16-byte load
        mode_load = 1'b1;
        tick();
        chk("load_state", state, 8'd1);
        for (int i = 0; i < 16; i++) wr_pulse(8'h10 + 8'(i), 4'(i), i == 15);
        chk("load_end_state", state, 8'd0);
        chk("load_end_done", load_done, 8'd0);

        // Prescaler /4 then switch to /16
        div_sel = 2'd1; run = 1'b1;
        tick();
        chk("run_state", state, 8'd2);
        for (int k = 0; k < 14; k++) begin
            chk("div4_ce", core_ce, (k % 4 == 3) ? 8'd1 : 8'd0);
            tick();
        end
        div_sel = 2'd2;
        #1;
        chk("divchg_ce", core_ce, 8'd0);
        for (int j = 1; j <= 17; j++) begin
            tick();
            chk("div16_ce", core_ce, (j == 16) ? 8'd1 : 8'd0);
        end
        run = 1'b0;
        #1;
        chk("stop_ce", core_ce, 8'd0);
        tick();
        chk("stop_state", state, 8'd0);

        // Breakpoint at pc=5, then a single step
        div_sel = 2'd0; bp_en = 1'b1; bp_addr = 4'd5; run = 1'b1;
        tick();
        for (int p = 0; p < 5; p++) begin
            pc = 4'(p);
            #1;
            chk("bp_pre_ce", core_ce, 8'd1);
            tick();
        end
        pc = 4'd5;
        #1;
        chk("bp_hit_ce", core_ce, 8'd0);
        tick();
        chk("halt_state", state, 8'd4);
        chk("halt_flag", halted, 8'd1);
        chk("halt_ce", core_ce, 8'd0);
        tick();
        step = 1'b1;
        tick();
        chk("step_edge_state", state, 8'd4);
        chk("step_edge_ce", core_ce, 8'd0);
        tick();
        chk("step_state", state, 8'd3);
        chk("step_ce", core_ce, 8'd1);
        chk("step_halted", halted, 8'd0);
        step = 1'b0;
        tick();
        chk("step_back_state", state, 8'd4);
        chk("step_back_ce", core_ce, 8'd0);

        // Resume past the breakpoint
        run = 1'b0;
        tick();
        chk("resume_wait", state, 8'd4);
        run = 1'b1;
        tick();
        chk("resume_state", state, 8'd2);
        chk("resume_ce", core_ce, 8'd1);
        tick();
        chk("rehit_ce", core_ce, 8'd0);
        tick();
        chk("rehit_state", state, 8'd4);
        bp_en = 1'b0; run = 1'b0;
        tick();
        run = 1'b1;
        tick();
        chk("exit_run", state, 8'd2);
        run = 1'b0;
        tick();
        chk("exit_idle", state, 8'd0);

        // Reset in the middle of a load
        mode_load = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) wr_pulse(8'hA0 + 8'(i), 4'(i), 1'b0);
        wr_data = 8'hA7; wr_strobe = 1'b1;
        tick();
        chk("pre_rst_we", prog_we, 8'd1);
        chk("pre_rst_addr", prog_addr, 8'd7);
        #2;
        rst_n = 1'b0; wr_strobe = 1'b0;
        #1;
        chk("async_rst_we", prog_we, 8'd0);
        chk("async_rst_addr", prog_addr, 8'd0);
        chk("async_rst_data", prog_wdata, 8'd0);
        chk("async_rst_state", state, 8'd0);
        #2;
        rst_n = 1'b1;
        #1;
        chk("post_rst_state", state, 8'd0);
        tick();
        chk("reload_state", state, 8'd1);
        wr_pulse(8'h55, 4'd0, 1'b0);
        mode_load = 1'b0;
        tick();
        chk("abort_state", state, 8'd0);
        chk("abort_done", load_done, 8'd0);

        // Freeze during run
        div_sel = 2'd1; run = 1'b1;
        tick();
        tick();
        tick();
        ena = 1'b0;
        #1;
        chk("frz_ce", core_ce, 8'd0);
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("frz_hold_ce", core_ce, 8'd0);
            chk("frz_hold_state", state, 8'd2);
        end
        ena = 1'b1;
        #1;
        chk("unfrz_ce0", core_ce, 8'd0);
        tick();
        chk("unfrz_ce1", core_ce, 8'd1);
        tick();
        chk("unfrz_ce2", core_ce, 8'd0);

        // Step from IDLE returns to IDLE
        run = 1'b0;
        tick();
        step = 1'b1;
        tick();
        tick();
        chk("idle_step_state", state, 8'd3);
        chk("idle_step_ce", core_ce, 8'd1);
        step = 1'b0;
        tick();
        chk("idle_step_back", state, 8'd0);
        chk("idle_step_ce_off", core_ce, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/td4_run_ctrl.md
TD4_RUN_CTRL -- requirements
Module: td4_run_ctrl

Interface
REQ-001 SHALL have parameter: SLOW_LOG2, default 8, log2 of the slowest clock-enable divide ratio (div_sel=3).
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ena  in  1  design-selected; low freezes all state
- mode_load  in  1  request program-load session
- wr_strobe  in  1  load write strobe, level; rising edge = one write
- wr_data  in  8  instruction byte to write
- run  in  1  level; high = free-run, low = pause
- step  in  1  level; rising edge = single step
- div_sel  in  2  core rate: 0=/1, 1=/4, 2=/16, 3=/2^SLOW_LOG2
- bp_en  in  1  breakpoint enable
- bp_addr  in  4  breakpoint PC
- pc  in  4  current core PC
- core_ce  out  1  one-cycle core clock-enable pulse
- prog_we  out  1  program-memory write enable
- prog_addr  out  4  program-memory write address
- prog_wdata  out  8  program-memory write data
- state  out  3  FSM state code
- halted  out  1  high in HALT
- load_done  out  1  one-cycle pulse at end of load

Function
REQ-003 SHALL implement FSM states, with encodings: IDLE=0, LOAD=1, RUN=2, STEP=3, HALT=4; state output equals the current code.
REQ-004 SHALL detect rising edges of wr_strobe and step from a one-cycle-delayed copy of each; an edge is seen one cycle after the input rises.
REQ-005 IDLE: mode_load=1 -> LOAD, addr=0; else run=1 -> RUN; else step edge -> STEP; mode_load has highest priority.
REQ-006 LOAD: each wr_strobe edge SHALL assert prog_we for exactly one cycle with prog_wdata=wr_data and prog_addr=current addr, then increment addr.
REQ-007 LOAD: the 16th write (addr=15) SHALL wrap addr to 0, pulse load_done for one cycle, and return to IDLE.
REQ-008 LOAD: mode_load deasserted before 16 writes SHALL abort to IDLE without load_done; writes already done stand.
REQ-009 RUN: prescaler counts every cycle; core_ce SHALL pulse one cycle each time the counter reaches its divide-1 terminal value (div_sel=0: every cycle); the counter then clears to 0.
REQ-010 A div_sel change SHALL clear the prescaler; the first pulse at the new rate then follows the full new period.
REQ-011 RUN: run=0 -> IDLE, prescaler cleared, no further core_ce.
REQ-012 Breakpoint: in RUN, when a pulse is due and bp_en=1 and pc==bp_addr and skip=0, SHALL suppress core_ce and enter HALT.
REQ-013 HALT: SHALL set skip=1; skip clears after the next issued core_ce.
REQ-014 HALT: a step edge -> STEP; run going from low to high -> RUN; mode_load -> LOAD.
REQ-015 STEP: SHALL issue exactly one core_ce on the entry cycle, ignoring prescaler and breakpoint; next state is HALT if it was entered from HALT, else IDLE.
REQ-016 core_ce and prog_we SHALL never both be high; neither SHALL be high outside RUN/STEP or LOAD respectively.
REQ-017 ena=0 SHALL force core_ce=0, prog_we=0, load_done=0 and hold all registers; edges occurring while ena=0 are lost.
REQ-018 halted SHALL be high exactly when state=HALT.

Reset
REQ-019 rst_n=0 SHALL asynchronously force state=IDLE, prescaler=0, addr=0, skip=0, edge-detect registers=0, and all outputs to 0.
REQ-020 Reset asserted mid-LOAD or mid-RUN SHALL abort with no further prog_we or core_ce; release resumes in IDLE.

Verification
REQ-021 Load: mode_load=1, 16 strobes with data 0x10..0x1F -> prog_we pulses at addr 0..15 with matching data, load_done one pulse, then state=0.
REQ-022 Rate: run=1, div_sel=1 -> core_ce every 4th cycle; switch to div_sel=2 -> first pulse 16 cycles after the change.
REQ-023 Breakpoint: bp_en=1, bp_addr=5, div_sel=0, pc driven 0..5 -> HALT at pc=5 with no ce; one step edge -> one ce, state back to HALT.
REQ-024 Resume: from REQ-023 HALT, toggle run 0->1 -> RUN; the first ce issues despite pc=5.
REQ-025 Reset: rst_n low mid-LOAD at addr 7 -> outputs 0 immediately without a clock edge; after release, state=IDLE and the next load starts at addr 0.
REQ-026 Freeze: ena=0 during RUN for 20 cycles -> no core_ce, state held; restoring ena=1 resumes the prescaler count.
